fc_sequencer: RTL and testbench
===============================

# fc_sequencer

Controller that sequences one FC training mini-batch through the FC top module (FC datapath plus FC memory). It streams weight banks, flattened input and right-answer vectors from an upstream valid/ready source into the FC memory via the external write port. It then runs forward computation, back propagation and batch-end handshakes for `BATCH` samples. It sits between the training controller (start/done/error) and the FC top module.

## Interface
- `FRT_CELL`, 14, input (flatten) cells
- `MID_CELL`, 10, hidden cells
- `BCK_CELL`, 5, output cells
- `BATCH`, 32, samples per mini-batch (1..255)
- `TIMEOUT`, 4096, max wait cycles for any FC handshake (2..65535)

- `clk` in 1, single clock, all logic on rising edge
- `reset` in 1, synchronous, active-high
- `start` in 1, begin a mini-batch (sampled in IDLE/ERR only)
- `reload_weights` in 1, sampled with `start`; forces weight reload
- `src_valid` in 1, upstream word valid
- `src_data` in 16, upstream word
- `src_ready` out 1, word accepted when `src_valid && src_ready`
- `ex_we`, `ex_value[15:0]`, `ex_addr[15:0]` out, FC memory external write
- `weight1`, `weight2`, `right_answer` out 1, FC bank select flags
- `enable` out 1, FC compute enable
- `bck_prop_start`, `batch_end` out 1, single-cycle pulses to FC
- `all_end`, `fc_bck_prop_end`, `fc_batch_end` in 1, FC completion flags
- `busy` out 1, state not IDLE/ERR
- `done` out 1, one-cycle pulse at batch completion
- `error` out 1, timeout sticky flag
- `phase` out 4, current state code
- `sample_cnt` out 8, samples finished in current batch

## Operation
- States/codes: IDLE 0, LOAD_W1 1, LOAD_W2 2, LOAD_IN 3, LOAD_ANS 4, RUN 5, BPROP 6, BEND 7, DONE 8, ERR 9.
- Load word counts N: W1 = FRT_CELL*MID_CELL, W2 = MID_CELL*BCK_CELL, IN = FRT_CELL, ANS = BCK_CELL.
- Internal `wvalid` flag: cleared by reset and by leaving ERR; set on leaving LOAD_W2.
- IDLE: on `start`, go to LOAD_W1 if `reload_weights || !wvalid`, else LOAD_IN. Clear `sample_cnt`.
- Load states:
  - `src_ready` is combinationally 1 throughout the state.
  - Word counter starts at 0 on entry and increments per accepted word.
  - Accepting word N-1 advances: W1→W2→IN→ANS→RUN.
- RUN: `enable`=1 until `all_end` is seen; then go to BPROP.
- BPROP: `bck_prop_start` pulses on the first BPROP cycle. Wait for `fc_bck_prop_end`, then increment `sample_cnt`.
  - If new count == BATCH, go to BEND; else go to LOAD_IN. Weights are not reloaded within a batch.
- BEND: `batch_end` pulses on the first cycle; wait for `fc_batch_end`, then go to DONE.
- DONE: one cycle, `done`=1, then IDLE. `sample_cnt` holds until the next start.
- Timeout: wait counter clears on entry to RUN/BPROP/BEND and increments each waiting cycle.
  - Reaching TIMEOUT-1 without the awaited flag → ERR.
- ERR: `error`=1 and all FC-facing outputs 0. `start` → IDLE, clearing `error` and `wvalid`.
- `start` outside IDLE/ERR is ignored. `reset` mid-operation returns to IDLE immediately; no partial load resumes.

## Timing
- All outputs except `src_ready` are registered.
- Reset values: all outputs 0; `phase`=0.
- Write path, fixed 1-cycle latency: accept at cycle t → cycle t+1 has `ex_we`=1, `ex_value`=word, `ex_addr`=word index (0..N-1).
- Flags are registered from the previous cycle's state:
  - `weight1` = (prev state LOAD_W1), `weight2` = LOAD_W2, `right_answer` = LOAD_ANS.
  - Each flag therefore stays valid on the final write cycle.
  - At most one flag is ever high.
- `enable` = registered (state==RUN).
  - It rises 1 cycle after RUN entry and falls 1 cycle after `all_end` is sampled.
  - `ex_we` is never 1 while `enable` is 1.
- `src_valid` gaps stall the load with no penalty; back-to-back accepts give one write per cycle.
- `bck_prop_start`/`batch_end` are high exactly one cycle, 1 cycle after state entry.
- A completion flag already high on the first cycle of its wait state is accepted.

## Test plan
- Params FRT=4, MID=3, BCK=2, BATCH=2. First `start` with continuous `src_valid` gives:
  - writes: 12 with `weight1`, 6 with `weight2`, 4 with no flag, 2 with `right_answer`; addresses 0..N-1 each.
  - then `enable` high until `all_end`.
- Full batch with FC model answering `all_end`/`fc_bck_prop_end` after 5 cycles:
  - sample 2 reloads only IN+ANS (6 writes).
  - `batch_end` pulses once, `done` pulses once, `sample_cnt`=2.
- Second `start` with `reload_weights`=0 → first write has no flag. With `reload_weights`=1 → 12 `weight1` writes.
- `src_valid` toggling 1/0 every cycle → 24 writes over 48 cycles with contiguous addresses and no duplicates.
- `all_end` withheld with TIMEOUT=16:
  - ERR entered after 15 RUN wait cycles; `error`=1, `enable`=0.
  - `start` clears `error`; the next `start` reloads weights.
- `reset` asserted mid LOAD_W2 → next cycle `phase`=0 and all outputs 0. A subsequent `start` begins at LOAD_W1.

Source files
------------

// File: rtl/fc_sequencer.sv
// Mini-batch sequencer for the FC top module: streams weights, inputs and answers
// into FC memory, then drives forward/back-prop/batch-end handshakes per sample.
module fc_sequencer #(
    parameter int unsigned FRT_CELL = 14,
    parameter int unsigned MID_CELL = 10,
    parameter int unsigned BCK_CELL = 5,
    parameter int unsigned BATCH    = 32,
    parameter int unsigned TIMEOUT  = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        reload_weights,
    input  logic        src_valid,
    input  logic [15:0] src_data,
    output logic        src_ready,
    output logic        ex_we,
    output logic [15:0] ex_value,
    output logic [15:0] ex_addr,
    output logic        weight1,
    output logic        weight2,
    output logic        right_answer,
    output logic        enable,
    output logic        bck_prop_start,
    output logic        batch_end,
    input  logic        all_end,
    input  logic        fc_bck_prop_end,
    input  logic        fc_batch_end,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [3:0]  phase,
    output logic [7:0]  sample_cnt
);

    localparam int unsigned AW = 16;
    localparam int unsigned CW = 16;
    localparam int unsigned SW = 8;

    localparam logic [AW-1:0] LAST_W1   = AW'(FRT_CELL * MID_CELL - 1);
    localparam logic [AW-1:0] LAST_W2   = AW'(MID_CELL * BCK_CELL - 1);
    localparam logic [AW-1:0] LAST_IN   = AW'(FRT_CELL - 1);
    localparam logic [AW-1:0] LAST_ANS  = AW'(BCK_CELL - 1);
    localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 2);
    localparam logic [SW-1:0] BATCH_N   = SW'(BATCH);

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        LOAD_W1  = 4'd1,
        LOAD_W2  = 4'd2,
        LOAD_IN  = 4'd3,
        LOAD_ANS = 4'd4,
        RUN      = 4'd5,
        BPROP    = 4'd6,
        BEND     = 4'd7,
        DONE     = 4'd8,
        ERR      = 4'd9
    } state_t;

    state_t          state;
    state_t          next_state;
    logic [AW-1:0]   word_cnt;
    logic [AW-1:0]   last_idx;
    logic [CW-1:0]   wait_cnt;
    logic            wvalid;
    logic            accept;
    logic            word_done;
    logic            wait_expired;
    logic            is_wait;
    logic            sample_inc;
    logic            enable_d;
    logic            bck_prop_start_d;
    logic            batch_end_d;

    assign src_ready    = (state == LOAD_W1) || (state == LOAD_W2) ||
                          (state == LOAD_IN) || (state == LOAD_ANS);
    assign accept       = src_valid && src_ready;
    assign word_done    = accept && (word_cnt == last_idx);
    assign is_wait      = (state == RUN) || (state == BPROP) || (state == BEND);
    assign wait_expired = (wait_cnt == WAIT_LAST);
    assign phase        = state;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode and next-cycle values of the registered FC strobes
    always_comb begin
        next_state       = state;
        last_idx         = LAST_ANS;
        sample_inc       = 1'b0;
        enable_d         = 1'b0;
        bck_prop_start_d = 1'b0;
        batch_end_d      = 1'b0;
        case (state)
            IDLE: begin
                if (start) next_state = (reload_weights || !wvalid) ? LOAD_W1 : LOAD_IN;
            end
            LOAD_W1: begin
                last_idx = LAST_W1;
                if (word_done) next_state = LOAD_W2;
            end
            LOAD_W2: begin
                last_idx = LAST_W2;
                if (word_done) next_state = LOAD_IN;
            end
            LOAD_IN: begin
                last_idx = LAST_IN;
                if (word_done) next_state = LOAD_ANS;
            end
            LOAD_ANS: begin
                last_idx = LAST_ANS;
                if (word_done) next_state = RUN;
            end
            RUN: begin
                if (all_end)           next_state = BPROP;
                else if (wait_expired) next_state = ERR;
            end
            BPROP: begin
                if (fc_bck_prop_end) begin
                    sample_inc = 1'b1;
                    next_state = (SW'(sample_cnt + 8'd1) == BATCH_N) ? BEND : LOAD_IN;
                end else if (wait_expired) begin
                    next_state = ERR;
                end
            end
            BEND: begin
                if (fc_batch_end)      next_state = DONE;
                else if (wait_expired) next_state = ERR;
            end
            DONE: next_state = IDLE;
            ERR: begin
                if (start) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
        // Strobes are suppressed when the wait times out so ERR shows no FC activity
        enable_d         = (state == RUN) && (next_state != ERR);
        bck_prop_start_d = (state == BPROP) && (wait_cnt == '0) && (next_state != ERR);
        batch_end_d      = (state == BEND) && (wait_cnt == '0) && (next_state != ERR);
    end

    // Counters, write path and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            word_cnt       <= '0;
            wait_cnt       <= '0;
            wvalid         <= 1'b0;
            ex_we          <= 1'b0;
            ex_value       <= '0;
            ex_addr        <= '0;
            weight1        <= 1'b0;
            weight2        <= 1'b0;
            right_answer   <= 1'b0;
            enable         <= 1'b0;
            bck_prop_start <= 1'b0;
            batch_end      <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            error          <= 1'b0;
            sample_cnt     <= '0;
        end else begin
            if (next_state != state) word_cnt <= '0;
            else if (accept)         word_cnt <= word_cnt + 16'd1;

            if (next_state != state) wait_cnt <= '0;
            else if (is_wait)        wait_cnt <= wait_cnt + 16'd1;

            if (state == ERR && next_state != ERR)            wvalid <= 1'b0;
            else if (state == LOAD_W2 && next_state != LOAD_W2) wvalid <= 1'b1;

            if (state == IDLE && start) sample_cnt <= '0;
            else if (sample_inc)        sample_cnt <= sample_cnt + 8'd1;

            ex_we <= accept;
            if (accept) begin
                ex_value <= src_data;
                ex_addr  <= word_cnt;
            end
            weight1        <= (state == LOAD_W1);
            weight2        <= (state == LOAD_W2);
            right_answer   <= (state == LOAD_ANS);
            enable         <= enable_d;
            bck_prop_start <= bck_prop_start_d;
            batch_end      <= batch_end_d;
            busy           <= (next_state != IDLE) && (next_state != ERR);
            done           <= (next_state == DONE);
            error          <= (next_state == ERR);
        end
    end

endmodule

// File: tb/tb_fc_sequencer.sv
// Randomized bench for fc_sequencer: a word-stream model predicts every FC memory
// write per mini-batch; a small FC responder answers the completion handshakes.
module tb_fc_sequencer;

    localparam int unsigned FRT = 4;
    localparam int unsigned MID = 3;
    localparam int unsigned BCK = 2;
    localparam int unsigned NB  = 2;
    localparam int unsigned TMO = 16;
    localparam int NW1 = FRT * MID;
    localparam int NW2 = MID * BCK;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        reload_weights = 1'b0;
    logic        src_valid = 1'b0;
    logic [15:0] src_data = '0;
    logic        src_ready;
    logic        ex_we;
    logic [15:0] ex_value;
    logic [15:0] ex_addr;
    logic        weight1;
    logic        weight2;
    logic        right_answer;
    logic        enable;
    logic        bck_prop_start;
    logic        batch_end;
    logic        all_end = 1'b0;
    logic        fc_bck_prop_end = 1'b0;
    logic        fc_batch_end = 1'b0;
    logic        busy;
    logic        done;
    logic        error;
    logic [3:0]  phase;
    logic [7:0]  sample_cnt;

    typedef struct packed {
        logic [1:0]  flag;
        logic [15:0] addr;
        logic [15:0] val;
    } wr_t;

    int checks = 0;
    int errors = 0;

    logic [15:0] acc_q[$];
    wr_t         wr_q[$];
    int          wr_cyc[$];
    int          src_mode = 0;
    bit          fc_hold = 1'b0;
    bit          m_wvalid = 1'b0;
    bit          tog = 1'b0;
    int          done_cnt = 0, be_cnt = 0, bps_cnt = 0, run_cycles = 0;
    int          overlap_cnt = 0, multi_cnt = 0, cyc = 0;
    int          en_run = 0, bp_t = 0, be_t = 0;

    fc_sequencer #(
        .FRT_CELL(FRT), .MID_CELL(MID), .BCK_CELL(BCK), .BATCH(NB), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .reload_weights(reload_weights),
        .src_valid(src_valid), .src_data(src_data), .src_ready(src_ready),
        .ex_we(ex_we), .ex_value(ex_value), .ex_addr(ex_addr),
        .weight1(weight1), .weight2(weight2), .right_answer(right_answer),
        .enable(enable), .bck_prop_start(bck_prop_start), .batch_end(batch_end),
        .all_end(all_end), .fc_bck_prop_end(fc_bck_prop_end), .fc_batch_end(fc_batch_end),
        .busy(busy), .done(done), .error(error), .phase(phase), .sample_cnt(sample_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] all_outs();
        return 64'({src_ready, ex_we, ex_value, ex_addr, weight1, weight2, right_answer,
                    enable, bck_prop_start, batch_end, busy, done, error, sample_cnt});
    endfunction

    // Upstream source: records every word that will be taken at the next rising edge
    initial begin
        forever begin
            @(negedge clk);
            case (src_mode)
                1:       src_valid = 1'b1;
                2:       begin tog = !tog; src_valid = tog; end
                3:       src_valid = ($urandom_range(0, 3) != 0);
                default: src_valid = 1'b0;
            endcase
            src_data = 16'($urandom);
            if (src_valid && src_ready && !reset) acc_q.push_back(src_data);
        end
    end

    // Output monitor
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (ex_we) begin
                wr_q.push_back({weight1 ? 2'd1 : weight2 ? 2'd2 : right_answer ? 2'd3 : 2'd0,
                                ex_addr, ex_value});
                wr_cyc.push_back(cyc);
            end
            if (int'(weight1) + int'(weight2) + int'(right_answer) > 1) multi_cnt++;
            if (ex_we && enable) overlap_cnt++;
            if (done) done_cnt++;
            if (batch_end) be_cnt++;
            if (bck_prop_start) bps_cnt++;
            if (phase == 4'd5) run_cycles++;
        end
    end

    // FC responder: each completion flag pulses five cycles after its trigger
    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                en_run = 0; bp_t = 0; be_t = 0;
                all_end = 1'b0; fc_bck_prop_end = 1'b0; fc_batch_end = 1'b0;
            end else begin
                en_run  = enable ? en_run + 1 : 0;
                all_end = !fc_hold && (en_run == 5);
                bp_t = bck_prop_start ? 1 : (bp_t != 0 ? bp_t + 1 : 0);
                fc_bck_prop_end = (bp_t == 5);
                if (bp_t == 5) bp_t = 0;
                be_t = batch_end ? 1 : (be_t != 0 ? be_t + 1 : 0);
                fc_batch_end = (be_t == 5);
                if (be_t == 5) be_t = 0;
            end
        end
    end

    task automatic run_batch(input bit rel, input int mode, input bit hold);
        bit  rel_eff;
        bit  finished;
        int  samples;
        int  idx;
        int  n_cmp;
        int  seg_f[$];
        int  seg_n[$];
        wr_t exp_q[$];
        wr_t e;
        rel_eff = rel || !m_wvalid;
        samples = hold ? 1 : NB;
        acc_q.delete(); wr_q.delete(); wr_cyc.delete();
        done_cnt = 0; be_cnt = 0; bps_cnt = 0; run_cycles = 0;
        src_mode = mode;
        fc_hold  = hold;
        @(negedge clk);
        start = 1'b1; reload_weights = rel;
        @(negedge clk);
        start = 1'b0; reload_weights = 1'b0;
        check("first_phase", phase, rel_eff ? 1 : 3);
        finished = 1'b0;
        for (int c = 0; c < 4000 && !finished; c++) begin
            @(negedge clk);
            if (done || error) finished = 1'b1;
        end
        check("finished", finished, 1);
        if (hold) begin
            check("err_flag", error, 1);
            check("err_enable", enable, 0);
            check("err_phase", phase, 9);
            check("run_wait", run_cycles, TMO - 1);
        end else begin
            check("done_phase", phase, 8);
        end
        repeat (2) @(negedge clk);

        if (rel_eff) begin
            seg_f.push_back(1); seg_n.push_back(NW1);
            seg_f.push_back(2); seg_n.push_back(NW2);
        end
        for (int s = 0; s < samples; s++) begin
            seg_f.push_back(0); seg_n.push_back(FRT);
            seg_f.push_back(3); seg_n.push_back(BCK);
        end
        idx = 0;
        foreach (seg_f[k]) begin
            for (int a = 0; a < seg_n[k]; a++) begin
                e.flag = 2'(seg_f[k]);
                e.addr = 16'(a);
                e.val  = (idx < acc_q.size()) ? acc_q[idx] : 16'hdead;
                exp_q.push_back(e);
                idx++;
            end
        end
        check("acc_count", acc_q.size(), exp_q.size());
        check("wr_count", wr_q.size(), exp_q.size());
        n_cmp = (wr_q.size() < exp_q.size()) ? wr_q.size() : exp_q.size();
        for (int i = 0; i < n_cmp; i++) check("wr", wr_q[i], exp_q[i]);
        if (mode == 2 && rel_eff && wr_cyc.size() >= 24)
            check("toggle_span", wr_cyc[23] - wr_cyc[0], 46);
        if (!hold) begin
            check("done_pulses", done_cnt, 1);
            check("batch_end_pulses", be_cnt, 1);
            check("bprop_pulses", bps_cnt, NB);
            check("sample_cnt", sample_cnt, NB);
            check("idle_phase", phase, 0);
            check("idle_busy", busy, 0);
        end
        if (rel_eff) m_wvalid = 1'b1;
        src_mode = 0;
    endtask

    task automatic clear_err();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("err_clear_phase", phase, 0);
        check("err_clear_flag", error, 0);
        m_wvalid = 1'b0;
    endtask

    task automatic reset_mid_w2();
        bit seen;
        seen = 1'b0;
        fc_hold  = 1'b0;
        src_mode = 1;
        @(negedge clk);
        start = 1'b1; reload_weights = 1'b1;
        @(negedge clk);
        start = 1'b0; reload_weights = 1'b0;
        for (int c = 0; c < 200 && !seen; c++) begin
            @(negedge clk);
            if (phase == 4'd2) seen = 1'b1;
        end
        check("reach_w2", seen, 1);
        src_mode = 0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("rst_mid_phase", phase, 0);
        check("rst_mid_outs", all_outs(), 0);
        reset = 1'b0;
        m_wvalid = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("reset_phase", phase, 0);
        check("reset_outs", all_outs(), 0);
        reset = 1'b0;

        run_batch(1'b1, 1, 1'b0);
        run_batch(1'b0, 1, 1'b0);
        run_batch(1'b1, 3, 1'b0);
        run_batch(1'b1, 2, 1'b0);
        run_batch(1'b0, 3, 1'b1);
        clear_err();
        run_batch(1'b0, 1, 1'b0);
        reset_mid_w2();
        run_batch(1'b0, 1, 1'b0);
        for (int i = 0; i < 3; i++) run_batch(1'($urandom_range(0, 1)), 3, 1'b0);

        check("we_enable_overlap", overlap_cnt, 0);
        check("multi_flag", multi_cnt, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
